bc_skid_buffer: RTL
===================

# bc_skid_buffer

Two-entry valid/ready register slice (skid buffer) that breaks the combinational ready path between a producer and a consumer. It is the downstream-driven counterpart of the enable-gated data register: instead of the producer deciding when data is captured, the consumer's ready decides when data leaves. All outputs are registered. It sits on any pipeline boundary in the basic circuit library where timing closure on `ready` is required.

## Interface
- WIDTH, 32, data width in bits
- INI_DATA, 0, value loaded into both data registers on reset
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset; synchronous and active-high
- iVld  input  1  upstream data valid
- oRdy  output  1  upstream ready, registered
- iDat  input  WIDTH  upstream data
- oVld  output  1  downstream data valid, registered
- iRdy  input  1  downstream ready
- oDat  output  WIDTH  downstream data, registered

## Operation
- Storage: main register (drives oDat) and skid register; each has its own valid flag.
- Upstream transfer: iVld && oRdy at a rising edge. Downstream transfer: oVld && iRdy at a rising edge.
- States (from the valid flags):
  - EMPTY: oVld=0, oRdy=1.
  - ONE: main full, skid empty; oVld=1, oRdy=1.
  - FULL: both full; oVld=1, oRdy=0.
- Transitions:
  - EMPTY: push -> ONE, main<=iDat.
  - ONE: push&&pop -> ONE, main<=iDat. Push only -> FULL, skid<=iDat. Pop only -> EMPTY. Neither -> ONE.
  - FULL: pop -> ONE, main<=skid. No pop -> FULL, hold.
- Push in FULL is impossible (oRdy=0). iDat is ignored in FULL regardless of iVld.
- Ordering is strictly FIFO. No data is dropped or duplicated.
- Data registers load only on the transitions above; otherwise they hold their value.
- Reset (rst high at an edge):
  - oVld=0, oRdy=1, oDat=INI_DATA, skid data=INI_DATA, state EMPTY.
  - Reset mid-operation discards both entries and overrides any simultaneous push or pop.

## Timing
- Latency from upstream transfer to oVld: 1 cycle (EMPTY -> ONE).
- Throughput: 1 transfer per cycle when iRdy is held high.
- oRdy falls in the cycle after the push that fills the skid register. It rises in the cycle after the pop that drains it.
- No combinational path from iRdy to oRdy, or from iVld/iDat to oVld/oDat.
- Within the reset cycle all outputs follow the previous register state. Reset values appear after the edge.

## Configuration
- Macro: BC_SKID_STALL_CNT_EN.
- Defined:
  - Adds output port oStallCnt [15:0].
  - Counts cycles with oVld && !iRdy, saturating at 16'hFFFF.
  - Cleared to 0 by rst.
  - Increments are visible one cycle after the stall cycle.
- Undefined: the port and counter logic do not exist. Datapath behaviour is identical either way.

## Structure
- Package bc_skid_pkg holds:
  - state enum {EMPTY, ONE, FULL} (2 bits)
  - localparam STALL_CNT_W = 16
- Sub-module bc_sat_cnt: generic saturating up-counter with width parameter, synchronous active-high clear and inc input. Instantiated only under BC_SKID_STALL_CNT_EN.

## Test plan
- Reset: hold rst=1 for 2 cycles, with INI_DATA=32'h1 -> oVld=0, oRdy=1, oDat=32'h1. With the macro defined, oStallCnt=0.
- Streaming: iRdy=1, push 32'hA0..32'hA7 on consecutive cycles -> oDat emits A0..A7 one cycle after each push, oVld continuous, oRdy never drops.
- Backpressure: iRdy=0, push 32'h11 then 32'h22 -> oRdy=0 after the second push, oDat=11, and 32'h33 offered on iDat is not taken. Then iRdy=1 for 2 cycles -> 11 then 22 emitted and oRdy=1.
- Simultaneous push/pop in ONE: main=32'h5, iVld=1, iDat=32'h6, iRdy=1 -> next cycle oDat=6, state ONE, oRdy=1.
- Reset mid-operation: reach FULL with 32'hDEAD/32'hBEEF, assert rst with iVld=1 and iRdy=1 -> next cycle oVld=0, oRdy=1, oDat=INI_DATA, and neither word is ever emitted.
- Stall counter (macro defined): hold oVld=1, iRdy=0 for 5 cycles -> oStallCnt=5. Force the count to 16'hFFFE, stall 3 more cycles -> oStallCnt stays at 16'hFFFF.

Source files
------------

// File: rtl/bc_skid_pkg.sv
// Shared types and constants for the bc_skid_buffer register slice.
// The state encoding is chosen so that the state register bits are
// directly the registered oVld/oRdy outputs: bit 1 = valid, bit 0 = ready.
package bc_skid_pkg;

  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'b01,  // nothing held, ready for data
    ONE   = 2'b11,  // main holds a word, skid free
    FULL  = 2'b10   // main and skid both hold words
  } state_t;

endpackage : bc_skid_pkg

// File: rtl/bc_sat_cnt.sv
// Generic saturating up-counter with synchronous active-high clear.
// Counts one per cycle while inc is high and holds at all-ones.
module bc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count register: clear wins, then increment until all-ones.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule : bc_sat_cnt

// File: rtl/bc_skid_buffer.sv
// Two-entry valid/ready skid buffer. All outputs come straight from flops,
// so there is no combinational path from iRdy to oRdy or from iVld/iDat
// to oVld/oDat. Words leave in strict FIFO order.
// Optional feature: define BC_SKID_STALL_CNT_EN to add oStallCnt, a
// saturating count of cycles with oVld high and iRdy low.
module bc_skid_buffer
  import bc_skid_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] INI_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iVld,
  output logic             oRdy,
  input  logic [WIDTH-1:0] iDat,
  output logic             oVld,
  input  logic             iRdy,
  output logic [WIDTH-1:0] oDat
`ifdef BC_SKID_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] oStallCnt
`endif
);

  state_t           state_q;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  logic push;
  logic pop;
  logic load_main;
  logic main_from_skid;
  logic load_skid;

  // Handshakes use only registered outputs, so they never feed back combinationally.
  assign push = iVld && oRdy;
  assign pop  = oVld && iRdy;

  // State register; reset discards both entries and overrides any push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state decode from occupancy and the two handshakes.
  always_comb begin
    // NOTE: assign a default first so every path drives the signal and no latch is inferred.
    state_nxt = state_q;
    case (state_q)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (!push && pop) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output and datapath-control decode; handshake outputs are the state bits.
  always_comb begin
    oVld           = state_q[1];
    oRdy           = state_q[0];
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: load_main = push;
      ONE: begin
        load_main = push && pop;
        load_skid = push && !pop;
      end
      FULL: begin
        load_main      = pop;
        main_from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  // Data registers load only on the transitions that move a word into them.
  always_ff @(posedge clk) begin
    // NOTE: only two storage words, and their reset value is architecturally visible on oDat, so both are reset.
    if (rst) begin
      main_q <= INI_DATA;
      skid_q <= INI_DATA;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : iDat;
      if (load_skid) skid_q <= iDat;
    end
  end

  assign oDat = main_q;

`ifdef BC_SKID_STALL_CNT_EN
  bc_sat_cnt #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .clr(rst),
    .inc(oVld && !iRdy),
    .cnt(oStallCnt)
  );
`endif

endmodule : bc_skid_buffer
